// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared definitions for the CPU-to-memory handshake bridge.
//   state_t                : bridge FSM encoding (IDLE, REQ, RESP, DONE)
//   ALIGN_MASK             : address bits that must be zero for a word access
//   DEFAULT_TIMEOUT_CYCLES : default response budget used with MEM_TIMEOUT_EN
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/mem_bridge_if.sv
// mem_bridge_if: valid/ready request channel plus rvalid response strobe
// between the bridge (master) and a variable-latency memory (slave).
//   mem_valid  master->slave  request valid, held until mem_ready
//   mem_ready  slave->master  request accepted
//   mem_we     master->slave  1 = write, 0 = read
//   mem_addr   master->slave  word-aligned byte address
//   mem_wdata  master->slave  write data
//   mem_rvalid slave->master  read data valid / write acknowledge
//   mem_rdata  slave->master  read data
interface mem_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/mem_bridge_wdog_counter.sv
// wdog_counter: saturating cycle counter for the bridge response timeout.
//   clk, reset : clock and synchronous active-high reset
//   clear_i    : restart counting from zero (wins over enable_i)
//   enable_i   : count this cycle
//   expired_o  : LIMIT counted cycles have been observed, including the
//                current one (cnt_q holds cycles seen so far minus one)
module wdog_counter #(
    parameter int unsigned LIMIT = 63
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q >= CW'(LIMIT - 1));

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: turns a one-cycle CPU access strobe into a valid/ready memory
// request and waits for the rvalid response, then pulses cpu_done.
//   clk, reset      : single clock, synchronous active-high reset
//   cpu_req/we/addr/wdata : access strobe and operands, sampled in IDLE only
//   cpu_busy        : high from the cycle after acceptance through cpu_done
//   cpu_done        : one-cycle completion pulse
//   cpu_err         : with cpu_done, misaligned address (or timeout)
//   cpu_rdata       : load data, held until the next read completion
//   mem             : mem_bridge_if master side (request + response)
// Optional feature: define MEM_TIMEOUT_EN to abort a transaction with
// cpu_err when no response arrives within TIMEOUT_CYCLES of acceptance.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_busy,
    output logic                  cpu_done,
    output logic                  cpu_err,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    mem_bridge_if.master          mem
);

    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  valid_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  misaligned;
    logic [ADDR_WIDTH-1:0] addr_aligned;
    logic                  wd_expired;

    assign misaligned   = |(cpu_addr[1:0] & ALIGN_MASK);
    assign addr_aligned = {cpu_addr[ADDR_WIDTH-1:2], cpu_addr[1:0] & ~ALIGN_MASK};

`ifdef MEM_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;

    assign wd_clear  = (state_q == IDLE) && cpu_req;
    assign wd_enable = (state_q == REQ) || (state_q == RESP);

    // The expiry decision is registered into DONE one cycle later, so the
    // counter fires one cycle early to land cpu_done TIMEOUT_CYCLES after
    // acceptance.
    wdog_counter #(
        .LIMIT (TIMEOUT_CYCLES - 1)
    ) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        addr_q  <= addr_aligned;
                        wdata_q <= cpu_wdata;
                        busy_q  <= 1'b1;
                        if (misaligned) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= REQ;
                            valid_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // A response arriving together with expiry still completes normally.
                    if (mem.mem_ready && mem.mem_rvalid) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= mem.mem_rdata;
                        end
                    end else if (wd_expired) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else if (mem.mem_ready) begin
                        state_q <= RESP;
                        valid_q <= 1'b0;
                    end
                end
                RESP: begin
                    if (mem.mem_rvalid) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= mem.mem_rdata;
                        end
                    end else if (wd_expired) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_busy      = busy_q;
    assign cpu_done      = done_q;
    assign cpu_err       = err_q;
    assign cpu_rdata     = rdata_q;
    assign mem.mem_valid = valid_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule
